// File: rtl/data_mem_responder.sv
// Data-memory responder for the datapath's load/store port.
// Word RAM with wait states, address window and alignment checks.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   MemRead    load request, held until ready
//   MemWrite   store request, held until ready
//   dAddress   byte address, sampled at acceptance
//   dWriteData store data, sampled at acceptance
//   dReadData  load data, valid with ready on a good read
//   ready      one-cycle completion pulse
//   error      with ready: request rejected, no state changed
//   busy       accepted request in flight
`timescale 1ns/1ps

module data_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  output logic [31:0] dReadData,
  output logic        ready,
  output logic        error,
  output logic        busy
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);
  localparam logic [3:0]  WC   = 4'(WAIT_CYCLES);

  // S_ACCESS is the edge that performs the RAM op and raises
  // ready; S_RESP is the ready cycle itself.
  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          wr_q;
  logic          bad_q;

  logic [31:0]   mem [DEPTH];

  logic [31:0]   off;
  logic          req;
  logic          bad_in;
  logic          we;

  // Unsigned offset: addresses below the base wrap high
  // and fail the range compare.
  assign off    = dAddress - BASE_ADDR;
  assign req    = MemRead | MemWrite;
  assign bad_in = (dAddress[1:0] != 2'b00)
                | (off >= SPAN)
                | (MemRead & MemWrite);

  assign we = (state == S_ACCESS) & wr_q & ~bad_q;

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[idx_q] <= wdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      idx_q     <= '0;
      wdata_q   <= 32'h0;
      wr_q      <= 1'b0;
      bad_q     <= 1'b0;
      dReadData <= 32'h0;
      ready     <= 1'b0;
      error     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req) begin
            idx_q   <= off[AW+1:2];
            wdata_q <= dWriteData;
            wr_q    <= MemWrite;
            bad_q   <= bad_in;
            cnt     <= WC;
            busy    <= 1'b1;
            state   <= (WAIT_CYCLES > 0) ? S_WAIT
                                         : S_ACCESS;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_ACCESS;
        end
        S_ACCESS: begin
          ready <= 1'b1;
          error <= bad_q;
          if (bad_q)      dReadData <= 32'h0;
          else if (!wr_q) dReadData <= mem[idx_q];
          state <= S_RESP;
        end
        S_RESP: begin
          ready <= 1'b0;
          error <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder.
// Two instances: WAIT_CYCLES=2 (a) and WAIT_CYCLES=0 (b).
`timescale 1ns/1ps

module tb_data_mem_responder;

  localparam logic [31:0] BASE  = 32'h10010000;
  localparam int          DEPTH = 1024;

  typedef struct {
    bit          chk;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        a_rd = 0, a_wr = 0;
  logic [31:0] a_ad = 0, a_wd = 0;
  logic [31:0] a_q;
  logic        a_rdy, a_err, a_busy;

  logic        b_rd = 0, b_wr = 0;
  logic [31:0] b_ad = 0, b_wd = 0;
  logic [31:0] b_q;
  logic        b_rdy, b_err, b_busy;

  int vectors = 0;
  int miscompares = 0;

  exp_t q0[$];
  exp_t q1[$];
  logic [31:0] mdl [int];
  logic [31:0] pool [16];

  always #5 clk = ~clk;

  data_mem_responder #(
    .BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(2)
  ) dut_a (
    .clk(clk), .rst(rst),
    .MemRead(a_rd), .MemWrite(a_wr),
    .dAddress(a_ad), .dWriteData(a_wd),
    .dReadData(a_q), .ready(a_rdy),
    .error(a_err), .busy(a_busy)
  );

  data_mem_responder #(
    .BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(0)
  ) dut_b (
    .clk(clk), .rst(rst),
    .MemRead(b_rd), .MemWrite(b_wr),
    .dAddress(b_ad), .dWriteData(b_wd),
    .dReadData(b_q), .ready(b_rdy),
    .error(b_err), .busy(b_busy)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Reference: rules applied to plain integers, memory
  // kept as a sparse word map.
  task automatic model(input bit rd, input bit wr,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       output exp_t e);
    longint unsigned la;
    bit bad;
    int w;
    la  = a;
    bad = (la % 4 != 0) || (la < BASE)
       || (la >= BASE + 4 * DEPTH) || (rd && wr);
    w   = int'((la - BASE) / 4);
    e.chk  = 1'b1;
    e.data = 32'h0;
    e.err  = bad;
    if (!bad && wr) begin
      mdl[w] = d;
      e.chk  = 1'b0;
    end else if (!bad) begin
      e.chk = mdl.exists(w);
      if (e.chk) e.data = mdl[w];
    end
  endtask

  task automatic drive(input bit b, input logic rd,
                       input logic wr,
                       input logic [31:0] a,
                       input logic [31:0] d);
    if (b) begin
      b_rd = rd; b_wr = wr; b_ad = a; b_wd = d;
    end else begin
      a_rd = rd; a_wr = wr; a_ad = a; a_wd = d;
    end
  endtask

  function automatic logic rdy(input bit b);
    return b ? b_rdy : a_rdy;
  endfunction

  // One transaction; caller is at a negedge with DUT idle.
  task automatic req(input bit b, input bit rd,
                     input bit wr,
                     input logic [31:0] a,
                     input logic [31:0] d,
                     input bit perturb);
    exp_t e;
    int n;
    model(rd, wr, a, d, e);
    if (b) q1.push_back(e);
    else   q0.push_back(e);
    drive(b, rd, wr, a, d);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("busy_after_accept",
            32'(b ? b_busy : a_busy), 32'd1);
        if (perturb)
          drive(b, rd, wr, a ^ 32'h40, ~d);
      end
    end while (!rdy(b) && n < 40);
    chk("latency", 32'(n), b ? 32'd2 : 32'd4);
    drive(b, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
  endtask

  task automatic mon(input string nm, input bit b,
                     input logic [31:0] q,
                     input logic er);
    exp_t e;
    if ((b ? q1.size() : q0.size()) == 0) begin
      chk({nm, "_unexpected_ready"}, 32'd1, 32'd0);
    end else begin
      e = b ? q1.pop_front() : q0.pop_front();
      chk({nm, "_error"}, 32'(er), 32'(e.err));
      if (e.chk) chk({nm, "_rdata"}, q, e.data);
    end
  endtask

  always @(negedge clk) if (a_rdy) mon("a", 1'b0, a_q, a_err);
  always @(negedge clk) if (b_rdy) mon("b", 1'b1, b_q, b_err);

  initial begin
    int n;
    int r;
    logic [31:0] ad;
    bit rd, wr;

    #22 rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("idle_outputs",
          {a_q[28:0], a_rdy, a_err, a_busy} |
          {b_q[28:0], b_rdy, b_err, b_busy}, 32'h0);
    end

    req(0, 0, 1, 32'h10010008, 32'hDEADBEEF, 0);
    req(0, 1, 0, 32'h10010008, 32'h0, 0);
    req(0, 0, 1, 32'h10010FFC, 32'hA5A55A5A, 0);
    req(0, 1, 0, 32'h10010FFC, 32'h0, 0);
    req(0, 1, 0, 32'h10011000, 32'h0, 0);
    req(0, 1, 0, 32'h1000FFFC, 32'h0, 0);
    req(0, 0, 1, 32'h10011000, 32'h77777777, 0);
    req(0, 1, 0, 32'h10010002, 32'h0, 0);
    req(0, 0, 1, 32'h10010010, 32'h12345678, 0);
    req(0, 1, 1, 32'h10010010, 32'h99999999, 0);
    req(0, 1, 0, 32'h10010010, 32'h0, 0);

    pool[0] = BASE;
    pool[1] = BASE + 4 * (DEPTH - 1);
    for (int i = 2; i < 16; i++)
      pool[i] = BASE + 4 * $urandom_range(0, DEPTH - 1);
    for (int i = 0; i < 16; i++)
      req(0, 0, 1, pool[i], $urandom, 0);

    for (int i = 0; i < 150; i++) begin
      r  = $urandom_range(0, 9);
      ad = pool[$urandom_range(0, 15)];
      if (r == 7) ad = ad + 32'($urandom_range(1, 3));
      if (r == 8) ad = BASE + 4 * DEPTH
                     + 4 * $urandom_range(0, 1000);
      if (r == 9) ad = BASE - 4 * $urandom_range(1, 1000);
      r  = $urandom_range(0, 9);
      rd = (r < 5) || (r == 9);
      wr = (r >= 5);
      req(0, rd, wr, ad, $urandom, 0);
    end

    req(0, 0, 1, pool[2], 32'h0BADF00D, 0);
    req(0, 0, 1, pool[2] ^ 32'h40, 32'h600DCAFE, 0);
    req(0, 1, 0, pool[2], 32'h0, 1);

    req(0, 0, 1, 32'h10010020, 32'h11111111, 0);
    req(0, 1, 0, 32'h10010020, 32'h0, 0);
    drive(0, 0, 1, 32'h10010020, 32'hCAFEF00D);
    @(negedge clk);
    chk("busy_in_wait", 32'(a_busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_outputs",
        {a_q[28:0], a_rdy, a_err, a_busy}, 32'h0);
    chk("async_reset_rdata", a_q, 32'h0);
    drive(0, 0, 0, 32'h0, 32'h0);
    #3 rst = 1'b1;
    repeat (10) @(negedge clk);
    req(0, 1, 0, 32'h10010020, 32'h0, 0);

    req(1, 0, 1, 32'h10010040, 32'h5EED1234, 0);
    req(1, 1, 0, 32'h10010040, 32'h0, 0);
    req(1, 1, 0, 32'h10010041, 32'h0, 0);

    begin
      exp_t e;
      model(1, 0, 32'h10010040, 32'h0, e);
      q1.push_back(e);
      q1.push_back(e);
    end
    drive(1, 1, 0, 32'h10010040, 32'h0);
    n = 0;
    do begin @(negedge clk); n++; end
    while (!b_rdy && n < 40);
    chk("hold_first_latency", 32'(n), 32'd2);
    n = 0;
    do begin @(negedge clk); n++; end
    while (!b_rdy && n < 40);
    chk("hold_second_gap", 32'(n), 32'd3);
    drive(1, 0, 0, 32'h0, 32'h0);
    repeat (10) @(negedge clk);

    chk("queue_a_drained", 32'(q0.size()), 32'd0);
    chk("queue_b_drained", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

endmodule
